// File: rtl/piso_serial_tx_if.sv
// ---------------------------------------------------------------------------
// piso_serial_tx_if
// Bundles the load handshake, bit-rate enable and serial status lines of the
// parallel-in/serial-out transmitter.
//
//   load_valid  producer -> tx   load_data is valid this cycle
//   load_ready  tx -> producer   transmitter accepts a word this cycle
//   load_data   producer -> tx   WIDTH-bit word to transmit
//   shift_en    producer -> tx   bit-rate enable, one bit consumed per high cycle
//   sout        tx -> consumer   registered serial data
//   sout_b      tx -> consumer   registered complement of sout
//   frame       tx -> consumer   high while a word's bits are on sout
//   done        tx -> consumer   one-cycle pulse after the last bit is consumed
//
// master: the side that supplies words and watches the serial outputs.
// slave : the transmitter itself.
// ---------------------------------------------------------------------------
interface piso_serial_tx_if #(
   parameter int WIDTH = 8
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic             shift_en;
   logic             sout;
   logic             sout_b;
   logic             frame;
   logic             done;

   modport master (
      output load_valid,
      output load_data,
      output shift_en,
      input  load_ready,
      input  sout,
      input  sout_b,
      input  frame,
      input  done
   );

   modport slave (
      input  load_valid,
      input  load_data,
      input  shift_en,
      output load_ready,
      output sout,
      output sout_b,
      output frame,
      output done
   );
endinterface

// File: rtl/piso_serial_tx.sv
// ---------------------------------------------------------------------------
// piso_serial_tx
// Parallel-in/serial-out transmitter. A WIDTH-bit word is accepted over a
// valid/ready handshake while idle and then shifted out one bit per cycle in
// which shift_en is high. sout, sout_b, frame and done all come straight from
// flops so the downstream capture stage sees clean registered lines.
//
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   synchronous active-high reset, priority over everything else
//   bus   piso_serial_tx_if.slave (load handshake, shift_en, serial outputs)
//
// Parameters:
//   WIDTH      bits per word, 2..32
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
// ---------------------------------------------------------------------------
module piso_serial_tx #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   piso_serial_tx_if.slave       bus
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q,  state_d;
   logic [CW-1:0]    count_q,  count_d;
   logic [WIDTH-1:0] shreg_q,  shreg_d;
   logic             sout_q,   sout_d;
   logic             sout_b_q, sout_b_d;
   logic             frame_q,  frame_d;
   logic             done_q,   done_d;

   // Next-state logic. The shift register always holds the bit currently on
   // sout at its outgoing end, so the next bit is read one position inward.
   // The count only reaches WIDTH-1, at which point the word is finished and
   // the machine leaves SHIFT, so it never wraps.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      shreg_d = shreg_q;
      sout_d  = sout_q;
      frame_d = frame_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            sout_d  = 1'b0;
            frame_d = 1'b0;
            if (bus.load_valid) begin
               state_d = SHIFT;
               count_d = '0;
               shreg_d = bus.load_data;
               sout_d  = (MSB_FIRST != 0) ? bus.load_data[WIDTH-1] : bus.load_data[0];
               frame_d = 1'b1;
            end
         end

         SHIFT: begin
            if (bus.shift_en) begin
               if (count_q == LAST) begin
                  state_d = DONE;
                  count_d = '0;
                  shreg_d = '0;
                  sout_d  = 1'b0;
                  frame_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  count_d = count_q + CW'(1);
                  if (MSB_FIRST != 0) begin
                     shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                     sout_d  = shreg_q[WIDTH-2];
                  end else begin
                     shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                     sout_d  = shreg_q[1];
                  end
               end
            end
         end

         DONE: begin
            state_d = IDLE;
            sout_d  = 1'b0;
            frame_d = 1'b0;
         end

         default: begin
            state_d = IDLE;
            count_d = '0;
            shreg_d = '0;
            sout_d  = 1'b0;
            frame_d = 1'b0;
         end
      endcase

      // Complement is computed from the same next value so the pair can
      // never disagree after the first edge.
      sout_b_d = ~sout_d;
   end

   // State and output registers; reset returns the line to its idle level.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         shreg_q  <= '0;
         sout_q   <= 1'b0;
         sout_b_q <= 1'b1;
         frame_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         shreg_q  <= shreg_d;
         sout_q   <= sout_d;
         sout_b_q <= sout_b_d;
         frame_q  <= frame_d;
         done_q   <= done_d;
      end
   end

   assign bus.load_ready = (state_q == IDLE);
   assign bus.sout       = sout_q;
   assign bus.sout_b     = sout_b_q;
   assign bus.frame      = frame_q;
   assign bus.done       = done_q;

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per enabled clock. Drives a registered serial line and its complement, with frame and done status. It is the driving end of the single-bit registered data paths built from our flip-flop primitives, and feeds a downstream serial capture stage.

Parameters:
WIDTH, 8, number of bits per word; legal range 2..32
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first

Ports:
clk  input  1  clock; all state changes on its rising edge
rst  input  1  reset, synchronous, active-high
load_valid  input  1  load_data is valid this cycle
load_ready  output  1  block accepts a word this cycle
load_data  input  WIDTH  word to transmit
shift_en  input  1  bit-rate enable; one bit is consumed per cycle with shift_en=1
sout  output  1  registered serial data
sout_b  output  1  registered complement of sout
frame  output  1  high while a word's bits are on sout
done  output  1  one-cycle pulse after the last bit is consumed

Behaviour:
- Reset:
  - rst=1 at a clk edge forces state=IDLE, bit count=0, shift register=0, sout=0, sout_b=1, frame=0, done=0.
  - rst has priority over all other inputs.
  - load_ready=1 from the cycle after the reset edge.
- sout_b is ~sout at all times after the first clock edge. Both are registered; no combinational path from any input to sout, sout_b, frame or done.
- load_ready is decoded from state: 1 only in IDLE.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - sout=0, frame=0, done=0.
  - load_valid=1 at an edge: capture load_data, count=0, go to SHIFT.
  - The first bit is on sout in the next cycle (bit WIDTH-1 if MSB_FIRST, else bit 0), and frame=1 in that cycle.
  - shift_en is ignored in IDLE.
- SHIFT:
  - frame=1 and sout holds the current bit.
  - shift_en=0: hold everything; a bit may be held indefinitely.
  - shift_en=1 and count<WIDTH-1: count+1, sout takes the next bit in order.
  - shift_en=1 and count=WIDTH-1: go to DONE.
  - load_valid is ignored (load_ready=0); load_data changes have no effect.
- DONE:
  - Lasts exactly one cycle: done=1, frame=0, sout=0, sout_b=1, load_ready=0.
  - Unconditionally returns to IDLE.
- Latency:
  - Accept edge to first bit on sout: 1 cycle.
  - With shift_en held at 1: frame high for WIDTH cycles, done in cycle WIDTH+1 after accept, load_ready in cycle WIDTH+2.
  - Minimum word-to-word spacing: WIDTH+2 cycles.
- Reset mid-frame: the frame is aborted at the reset edge, no done pulse, outputs take reset values, and the partial word is discarded.
- Simultaneous rst and load_valid: rst wins; the word is not accepted.
- Count width is clog2(WIDTH); the count never wraps because SHIFT exits at WIDTH-1.
- No X on any output after reset, including when load_data contains X while not accepted.

Test Plan:
1. Reset: rst=1 for 2 cycles with random inputs -> sout=0, sout_b=1, frame=0, done=0; load_ready=1 the cycle after rst drops.
2. MSB_FIRST=1, load 8'hA5, shift_en=1 constantly -> sout cycles 1..8 = 1,0,1,0,0,1,0,1; sout_b inverse; frame=1 cycles 1..8; done=1 at cycle 9 only; load_ready=1 at cycle 10.
3. Gapped enable: load 8'hC3, shift_en=1 every 3rd cycle -> each bit held exactly 3 cycles (first bit held until first enable); 1,1,0,0,0,0,1,1 observed; done one cycle after the 8th enable.
4. MSB_FIRST=0, load 8'h01 -> sout = 1,0,0,0,0,0,0,0; then load 8'h80 back-to-back when load_ready returns -> 0,0,0,0,0,0,0,1.
5. Busy: during SHIFT of 8'hFF, assert load_valid with 8'h00 -> ignored; sout stays 1 for all 8 bits; the next word is accepted only when load_ready=1.
6. Mid-frame reset: rst=1 after the 4th bit of 8'hF0 -> next cycle frame=0, sout=0, sout_b=1, done never pulses; a new load of 8'h0F then transmits 0,0,0,0,1,1,1,1 correctly.
